me_window_feeder: RTL and testbench

- Producer side of the motion-estimation core's 16-lane frame bus.
- Accepts one 8x8 current block and its 23x23 reference search window over a 64-bit valid/ready load stream into a ping-pong buffer.
- Replays the block on crt_frame and pre_frame in the core's fixed 25-cycle round: phase 0..7 current rows, phases 0..22 window rows, 16 lanes each offset by horizontal displacement i.

---
 rtl/me_pkg.sv | 30 +++
 rtl/me_pingpong_bank.sv | 56 +++++
 rtl/me_window_feeder.sv | 137 +++++++++++++
 tb/tb_me_window_feeder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimation window feeder.
// Geometry is fixed at the defaults: 8x8 block, 16 search lanes, 23x23 window.
package me_pkg;

  localparam int PIX_W         = 8;
  localparam int BLK           = 8;
  localparam int RANGE         = 16;
  localparam int WIN           = BLK + RANGE - 1;
  localparam int PERIOD        = 25;

  localparam int BEAT_W        = BLK * PIX_W;      // one load beat / one lane
  localparam int LANE_W        = BLK * PIX_W;
  localparam int ROW_W         = WIN * PIX_W;      // one full window row
  localparam int FRAME_W       = RANGE * LANE_W;

  localparam int CUR_BEATS     = 8;
  localparam int WIN_BEATS_ROW = 3;
  localparam int BEATS_PER_BLK = CUR_BEATS + WIN * WIN_BEATS_ROW;  // 77

  typedef enum logic {
    LD_FILL,
    LD_FULL
  } load_state_t;

  // Lane i sees the window row starting at horizontal displacement i.
  function automatic int lane_off(input int lane);
    return lane * PIX_W;
  endfunction

endpackage

// File: rtl/me_pingpong_bank.sv
// Storage for one block: 8 current rows and 23 window rows.
// Beat-indexed write port, combinational row read from registered storage.
module me_pingpong_bank
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [6:0]        beat,
  input  logic [BEAT_W-1:0] wdata,
  input  logic [2:0]        cur_idx,
  input  logic [4:0]        win_idx,
  output logic [BEAT_W-1:0] cur_row,
  output logic [ROW_W-1:0]  win_row
);

  logic [BEAT_W-1:0] cur_mem [CUR_BEATS];
  logic [ROW_W-1:0]  win_mem [WIN];

  logic       is_cur;
  logic [6:0] win_beat;
  logic [4:0] w_row;
  logic [1:0] w_part;

  always_comb begin
    is_cur   = beat < 7'(CUR_BEATS);
    win_beat = beat - 7'(CUR_BEATS);
    w_row    = 5'(win_beat / 7'd3);
    w_part   = 2'(win_beat % 7'd3);
  end

  // Third beat of a window row carries only pixels 16..22; its top byte is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < CUR_BEATS; r++) cur_mem[r] <= '0;
      for (int r = 0; r < WIN; r++)       win_mem[r] <= '0;
    end else if (we) begin
      if (is_cur) begin
        cur_mem[beat[2:0]] <= wdata;
      end else if (w_row < 5'(WIN)) begin
        case (w_part)
          2'd0:    win_mem[w_row][63:0]    <= wdata;
          2'd1:    win_mem[w_row][127:64]  <= wdata;
          default: win_mem[w_row][183:128] <= wdata[55:0];
        endcase
      end
    end
  end

  always_comb begin
    cur_row = cur_mem[cur_idx];
    win_row = '0;
    if (win_idx < 5'(WIN)) win_row = win_mem[win_idx];
  end

endmodule

// File: rtl/me_window_feeder.sv
// Loads a current block plus search window into a ping-pong buffer and replays
// it on the 16-lane frame bus in a free-running 25-cycle round.
module me_window_feeder
  import me_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BEAT_W-1:0]  in_data,
  input  logic               clr,
  output logic [FRAME_W-1:0] crt_frame,
  output logic [FRAME_W-1:0] pre_frame,
  output logic               round_start,
  output logic               blk_valid,
  output logic               underrun
);

  logic [4:0]  ph_reg;
  load_state_t ld_state_reg, ld_state_next;
  logic [6:0]  beat_cnt_reg, beat_cnt_next;
  logic        ptr_reg;
  logic        blk_valid_reg;
  logic        underrun_reg;

  logic boundary;
  logic accept;
  logic last_beat;
  logic shadow_full;

  assign boundary    = ph_reg == 5'(PERIOD - 1);
  assign shadow_full = ld_state_reg == LD_FULL;
  assign in_ready    = !shadow_full && !clr;
  assign accept      = in_valid && in_ready;
  assign last_beat   = beat_cnt_reg == 7'(BEATS_PER_BLK - 1);

  // Free-running phase; leaves reset together with the core so both agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ph_reg <= '0;
    else if (boundary) ph_reg <= '0;
    else               ph_reg <= ph_reg + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_reg <= LD_FILL;
      beat_cnt_reg <= '0;
    end else begin
      ld_state_reg <= ld_state_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    ld_state_next = ld_state_reg;
    beat_cnt_next = beat_cnt_reg;
    if (clr) begin
      ld_state_next = LD_FILL;
      beat_cnt_next = '0;
    end else begin
      case (ld_state_reg)
        LD_FILL: begin
          if (accept) begin
            if (last_beat) begin
              ld_state_next = LD_FULL;
              beat_cnt_next = '0;
            end else begin
              beat_cnt_next = beat_cnt_reg + 7'd1;
            end
          end
        end
        LD_FULL: begin
          if (boundary) ld_state_next = LD_FILL;
        end
        default: ld_state_next = LD_FILL;
      endcase
    end
  end

  // Swap samples the pre-edge shadow state, so a block finishing on the
  // boundary edge waits one full round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= 1'b0;
      blk_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else if (boundary) begin
      if (shadow_full) begin
        ptr_reg       <= ~ptr_reg;
        blk_valid_reg <= 1'b1;
        underrun_reg  <= 1'b0;
      end else begin
        blk_valid_reg <= 1'b0;
        underrun_reg  <= 1'b1;
      end
    end else begin
      underrun_reg <= 1'b0;
    end
  end

  logic [BEAT_W-1:0] cur_row [2];
  logic [ROW_W-1:0]  win_row [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    me_pingpong_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (accept && (ptr_reg != 1'(gi))),
      .beat    (beat_cnt_reg),
      .wdata   (in_data),
      .cur_idx (ph_reg[2:0]),
      .win_idx (ph_reg),
      .cur_row (cur_row[gi]),
      .win_row (win_row[gi])
    );
  end

  logic [BEAT_W-1:0] act_cur;
  logic [ROW_W-1:0]  act_win;
  logic              cur_on;
  logic              pre_on;

  assign act_cur = cur_row[ptr_reg];
  assign act_win = win_row[ptr_reg];
  assign cur_on  = blk_valid_reg && (ph_reg < 5'(BLK));
  assign pre_on  = blk_valid_reg && (ph_reg < 5'(WIN));

  for (genvar gi = 0; gi < RANGE; gi++) begin : g_lane
    assign crt_frame[gi*LANE_W +: LANE_W] = cur_on ? act_cur : '0;
    assign pre_frame[gi*LANE_W +: LANE_W] = pre_on ? act_win[lane_off(gi) +: LANE_W] : '0;
  end

  assign round_start = ph_reg == 5'd0;
  assign blk_valid   = blk_valid_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_me_window_feeder.sv
// Scoreboard bench for me_window_feeder: a pixel-level model predicts every
// cycle's outputs into a queue, and a negedge monitor pops and compares.
module tb_me_window_feeder;
  import me_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               clr = 1'b0;
  logic [63:0]        in_data = '0;
  logic               in_ready;
  logic [1023:0]      crt_frame;
  logic [1023:0]      pre_frame;
  logic               round_start;
  logic               blk_valid;
  logic               underrun;

  always #5 clk = ~clk;

  me_window_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .clr         (clr),
    .crt_frame   (crt_frame),
    .pre_frame   (pre_frame),
    .round_start (round_start),
    .blk_valid   (blk_valid),
    .underrun    (underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, got timeout want event at %0t", name, $time);
  endtask

  // ---------------- reference model (pixel arrays, spec rules) ----------------
  typedef struct {
    bit            rs;
    bit            bv;
    bit            ur;
    bit            full;
    logic [1023:0] crt;
    logic [1023:0] pre;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] act_cur [8][8];
  logic [7:0] act_win [23][23];
  logic [7:0] sh_cur  [8][8];
  logic [7:0] sh_win  [23][23];
  int m_ph, m_cnt;
  bit m_full, m_bv, m_ur;

  task automatic model_reset();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
      act_cur[r][c] = '0; sh_cur[r][c] = '0;
    end
    for (int r = 0; r < 23; r++) for (int c = 0; c < 23; c++) begin
      act_win[r][c] = '0; sh_win[r][c] = '0;
    end
    m_ph = 0; m_cnt = 0; m_full = 0; m_bv = 0; m_ur = 0;
  endtask

  task automatic model_step(input bit v, input bit c, input logic [63:0] d);
    bit acc;
    int b, r, p, col;
    acc = v && !m_full && !c;
    if (m_ph == PERIOD - 1) begin
      if (m_full) begin
        act_cur = sh_cur;
        act_win = sh_win;
        m_bv = 1; m_full = 0; m_ur = 0;
      end else begin
        m_bv = 0; m_ur = 1;
      end
    end else begin
      m_ur = 0;
    end
    if (c) begin
      m_cnt = 0; m_full = 0;
    end else if (acc) begin
      b = m_cnt;
      if (b < 8) begin
        for (int k = 0; k < 8; k++) sh_cur[b][k] = d[8*k +: 8];
      end else begin
        r = (b - 8) / 3;
        p = (b - 8) % 3;
        for (int k = 0; k < 8; k++) begin
          col = 8 * p + k;
          if (col < 23) sh_win[r][col] = d[8*k +: 8];
        end
      end
      if (b == BEATS_PER_BLK - 1) begin m_full = 1; m_cnt = 0; end
      else m_cnt = b + 1;
    end
    m_ph = (m_ph == PERIOD - 1) ? 0 : m_ph + 1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.rs = (m_ph == 0);
    e.bv = m_bv;
    e.ur = m_ur;
    e.full = m_full;
    e.crt = '0;
    e.pre = '0;
    for (int i = 0; i < 16; i++) for (int k = 0; k < 8; k++) begin
      if (m_bv && m_ph < 8)  e.crt[64*i + 8*k +: 8] = act_cur[m_ph][k];
      if (m_bv && m_ph < 23) e.pre[64*i + 8*k +: 8] = act_win[m_ph][i + k];
    end
    exp_q.push_back(e);
  endtask

  initial begin
    bit rst_prev;
    rst_prev = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n or posedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else if (!rst_prev) begin
        push_exp();
      end else begin
        model_step(in_valid, clr, in_data);
        push_exp();
      end
      rst_prev = rst_n;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_round_start", 64'(round_start), 64'd1);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'(!clr));
        chk("rst_crt", 64'(|crt_frame), 64'd0);
        chk("rst_pre", 64'(|pre_frame), 64'd0);
      end else if (exp_q.size() == 0) begin
        fail_bound("scoreboard_empty");
      end else begin
        e = exp_q.pop_front();
        chk("round_start", 64'(round_start), 64'(e.rs));
        chk("blk_valid", 64'(blk_valid), 64'(e.bv));
        chk("underrun", 64'(underrun), 64'(e.ur));
        chk("in_ready", 64'(in_ready), 64'(!e.full && !clr));
        for (int i = 0; i < 16; i++) begin
          chk($sformatf("crt_lane%0d", i), crt_frame[64*i +: 64], e.crt[64*i +: 64]);
          chk($sformatf("pre_lane%0d", i), pre_frame[64*i +: 64], e.pre[64*i +: 64]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] beats [77];

  task automatic make_block(input bit pattern);
    int col;
    logic [7:0] v;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) begin
      v = pattern ? 8'(r) : 8'($urandom);
      beats[r][8*k +: 8] = v;
    end
    for (int r = 0; r < 23; r++) for (int p = 0; p < 3; p++) for (int k = 0; k < 8; k++) begin
      col = 8 * p + k;
      v = (pattern && col < 23) ? 8'(16 * r + col) : 8'($urandom);
      beats[8 + 3*r + p][8*k +: 8] = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int t;
    bit ok;
    t = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) break;
      t++;
      if (t > 200) begin fail_bound("accept_timeout"); break; end
    end
  endtask

  task automatic send_beats(input int first, input int last, input bit gaps);
    for (int b = first; b <= last; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 0;
        tick();
      end
      in_valid = 1;
      in_data = beats[b];
      wait_accept();
    end
  endtask

  task automatic wait_for(input int ph, input bit need_bv);
    bit found;
    found = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (m_ph == ph && (!need_bv || m_bv)) begin found = 1; break; end
    end
    if (!found) fail_bound($sformatf("wait_ph%0d", ph));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    // Reset and three idle rounds.
    tick();
    rst_n = 1;
    repeat (75) tick();

    // Known pattern block.
    make_block(1);
    send_beats(0, 76, 0);
    in_valid = 0;
    wait_for(3, 1);
    chk("pat_crt_ph3_lane7", crt_frame[64*7 +: 64], 64'h0303030303030303);
    wait_for(10, 1);
    chk("pat_pre_ph10_lane5", pre_frame[64*5 +: 64], 64'hACABAAA9A8A7A6A5);
    chk("pat_pre_ph10_lane15", pre_frame[64*15 +: 64], 64'hB6B5B4B3B2B1B0AF);
    wait_for(23, 1);
    chk("pat_pre_ph23", 64'(|pre_frame), 64'd0);
    tick();

    // Back-to-back streaming, valid held high across A and B.
    make_block(0);
    send_beats(0, 76, 0);
    make_block(0);
    send_beats(0, 76, 0);
    in_valid = 0;
    repeat (60) tick();

    // Beat 76 lands exactly on the round boundary edge.
    make_block(0);
    send_beats(0, 75, 0);
    in_valid = 0;
    for (int t = 0; t < 60; t++) begin
      if (m_ph == PERIOD - 1) break;
      tick();
    end
    in_valid = 1;
    in_data = beats[76];
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("late_underrun", 64'(underrun), 64'd1);
    chk("late_blk_valid", 64'(blk_valid), 64'd0);
    repeat (25) @(negedge clk);
    chk("late_next_round_valid", 64'(blk_valid), 64'd1);
    tick();
    repeat (30) tick();

    // Abort a partial load, then reload a different block.
    make_block(0);
    send_beats(0, 40, 1);
    clr = 1;
    in_valid = 1;
    in_data = beats[41];
    tick();
    clr = 0;
    in_valid = 0;
    make_block(0);
    send_beats(0, 76, 1);
    in_valid = 0;
    repeat (60) tick();

    // Reset mid-round with an active block and a partly loaded shadow.
    make_block(0);
    send_beats(0, 76, 0);
    make_block(0);
    send_beats(0, 11, 0);
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("midrst_round_start", 64'(round_start), 64'd1);
    chk("midrst_blk_valid", 64'(blk_valid), 64'd0);
    chk("midrst_crt", 64'(|crt_frame), 64'd0);
    chk("midrst_pre", 64'(|pre_frame), 64'd0);
    tick();
    tick();
    rst_n = 1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
